serial_subtractor: RTL

Bit-serial, LSB-first unsigned/two's-complement subtractor computing Diff = Ain − Bin over WIDTH clock cycles using one full-subtractor cell and a registered borrow. It is the inverse-operation counterpart of the one-bit full adder cell in the arithmetic library. It targets area-constrained datapaths that can trade latency for logic. A start/busy/done handshake sequences each operation.

---
 rtl/serial_subtractor_pkg.sv | 21 ++
 rtl/serial_subtractor_full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 132 +++++++++++++
 3 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the width helper used to size the bit counter.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Ceiling log2, floored at 1 so a counter is never zero bits wide.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: diff = ain - bin - bin_b, with borrow out.
module full_subtractor (
    input  logic ain,
    input  logic bin,
    input  logic bin_b,
    output logic diff,
    output logic bout
);

    assign diff = ain ^ bin ^ bin_b;
    assign bout = (~ain & bin) | (~ain & bin_b) | (bin & bin_b);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: one full-subtractor cell reused over WIDTH
// cycles, sequenced by a start/busy/done handshake.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CNT_W = clog2(WIDTH);

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   a_reg, a_next;
    logic [WIDTH-1:0]   b_reg, b_next;
    logic [WIDTH-1:0]   res_reg, res_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               br_reg, br_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic [WIDTH-1:0]   diff_reg, diff_next;
    logic               bout_reg, bout_next;
    logic               ovf_reg, ovf_next;
    logic               cell_d, cell_bout;
    logic               last_bit;

    full_subtractor u_cell (
        .ain   (a_reg[0]),
        .bin   (b_reg[0]),
        .bin_b (br_reg),
        .diff  (cell_d),
        .bout  (cell_bout)
    );

    assign last_bit = (cnt_reg == CNT_W'(WIDTH - 1));

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        res_next   = res_reg;
        cnt_next   = cnt_reg;
        br_next    = br_reg;
        busy_next  = 1'b0;
        done_next  = 1'b0;
        diff_next  = diff_reg;
        bout_next  = bout_reg;
        ovf_next   = ovf_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RUN;
                    a_next     = ain;
                    b_next     = bin;
                    res_next   = '0;
                    cnt_next   = '0;
                    br_next    = 1'b0;
                    busy_next  = 1'b1;
                end
            end
            ST_RUN: begin
                busy_next = 1'b1;
                a_next    = {1'b0, a_reg[WIDTH-1:1]};
                b_next    = {1'b0, b_reg[WIDTH-1:1]};
                res_next  = {cell_d, res_reg[WIDTH-1:1]};
                br_next   = cell_bout;
                cnt_next  = cnt_reg + CNT_W'(1);
                if (last_bit) begin
                    // Counter is held here so it never wraps; br_reg is the borrow into the MSB.
                    state_next = ST_DONE;
                    cnt_next   = cnt_reg;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    diff_next  = {cell_d, res_reg[WIDTH-1:1]};
                    bout_next  = cell_bout;
                    ovf_next   = br_reg ^ cell_bout;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            cnt_reg   <= '0;
            br_reg    <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            diff_reg  <= '0;
            bout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            res_reg   <= res_next;
            cnt_reg   <= cnt_next;
            br_reg    <= br_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            diff_reg  <= diff_next;
            bout_reg  <= bout_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign diff = diff_reg;
    assign bout = bout_reg;
    assign ovf  = ovf_reg;

endmodule
